// File: rtl/mac_mgnt_push.sv
// Per-frame statistics producer: queues {flags,len} records and hands them to the
// management counter block over a 4-phase valid/resp handshake with a locally synchronised resp.
module mac_mgnt_push #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FLAG_WIDTH  = 8,
  parameter int LEN_WIDTH   = 12,
  parameter int SYNC_STAGES = 2,
  localparam int DW = FLAG_WIDTH + LEN_WIDTH
) (
  input  logic                  clk_if,
  input  logic                  rst_if,
  input  logic                  stat_valid,
  input  logic [FLAG_WIDTH-1:0] stat_flags,
  input  logic [LEN_WIDTH-1:0]  stat_len,
  output logic                  mgnt_valid,
  input  logic                  mgnt_resp,
  output logic [DW-1:0]         mgnt_data,
  output logic                  fifo_full,
  output logic [15:0]           drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_LOAD = 5'b00010;
  localparam logic [4:0] S_REQ  = 5'b00100;
  localparam logic [4:0] S_WACK = 5'b01000;
  localparam logic [4:0] S_WREL = 5'b10000;

  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_reg;
  logic [AW:0]            rd_ptr_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [4:0]             state_reg;
  logic [4:0]             state_next;
  logic                   resp_s;
  logic                   empty;
  logic                   pop;
  logic                   push;
  logic                   drop;

  assign resp_s    = sync_reg[SYNC_STAGES-1];
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop       = (state_reg == S_LOAD);
  // A pop in the same cycle frees the slot, so a write on full is still accepted.
  assign push      = stat_valid && (!fifo_full || pop);
  assign drop      = stat_valid && fifo_full && !pop;

  always_ff @(posedge clk_if) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {stat_flags, stat_len};
    end
  end

  always_ff @(posedge clk_if or negedge rst_if) begin
    if (!rst_if) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      drop_cnt   <= '0;
      sync_reg   <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], mgnt_resp};
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // stat_valid counts as non-empty in IDLE so a fresh record is loaded one cycle after its pulse.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if ((!empty || stat_valid) && !resp_s) state_next = S_LOAD;
      S_LOAD: state_next = S_REQ;
      S_REQ:  state_next = S_WACK;
      S_WACK: if (resp_s) state_next = S_WREL;
      S_WREL: if (!resp_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_if or negedge rst_if) begin
    if (!rst_if) begin
      state_reg  <= S_IDLE;
      mgnt_valid <= 1'b0;
      mgnt_data  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_LOAD: mgnt_data <= mem[rd_ptr_reg[AW-1:0]];
        S_REQ:  mgnt_valid <= 1'b1;
        S_WACK: if (resp_s) mgnt_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_mgnt_push.sv
// Directed/randomised bench for mac_mgnt_push; records are predicted by a queue model
// built from the capacity rule (one record in flight plus FIFO_DEPTH queued).
module tb_mac_mgnt_push;

  localparam int FD = 4;
  localparam int FW = 8;
  localparam int LW = 12;
  localparam int SS = 2;
  localparam int DW = FW + LW;

  logic          clk_if     = 1'b0;
  logic          rst_if     = 1'b0;
  logic          stat_valid = 1'b0;
  logic [FW-1:0] stat_flags = '0;
  logic [LW-1:0] stat_len   = '0;
  logic          mgnt_resp  = 1'b0;
  logic          mgnt_valid;
  logic [DW-1:0] mgnt_data;
  logic          fifo_full;
  logic [15:0]   drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rec = '0;
  int            occ      = 0;
  bit            inflight = 1'b0;
  int            exp_drop = 0;

  mac_mgnt_push #(
    .FIFO_DEPTH (FD),
    .FLAG_WIDTH (FW),
    .LEN_WIDTH  (LW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_if    (clk_if),
    .rst_if    (rst_if),
    .stat_valid(stat_valid),
    .stat_flags(stat_flags),
    .stat_len  (stat_len),
    .mgnt_valid(mgnt_valid),
    .mgnt_resp (mgnt_resp),
    .mgnt_data (mgnt_data),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_if = ~clk_if;

  task automatic step();
    @(posedge clk_if);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a record is either taken straight into flight, queued if there is room, or dropped.
  task automatic model_push(input logic [DW-1:0] rec);
    if (!inflight && occ == 0) begin
      inflight = 1'b1;
      exp_q.push_back(rec);
    end else if (occ < FD) begin
      occ++;
      exp_q.push_back(rec);
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endtask

  task automatic model_release();
    inflight = 1'b0;
    if (occ > 0) begin
      occ--;
      inflight = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ      = 0;
    inflight = 1'b0;
    exp_drop = 0;
  endtask

  task automatic drive(input logic [DW-1:0] rec);
    stat_valid = 1'b1;
    {stat_flags, stat_len} = rec;
    model_push(rec);
    step();
    stat_valid = 1'b0;
  endtask

  task automatic accept_front(input string tag);
    int n;
    logic [DW-1:0] e;
    n = 0;
    while (mgnt_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_valid_rise"}, {31'd0, mgnt_valid}, 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    last_rec = e;
    chk({tag, "_data"}, {12'd0, mgnt_data}, {12'd0, e});
    $display("rec %s: data=%05h expected=%05h drop_cnt=%0d", tag, mgnt_data, e, drop_cnt);
  endtask

  // Valid must fall exactly SS+1 cycles after resp rises, with data held throughout.
  task automatic ack_raise(input string tag);
    mgnt_resp = 1'b1;
    for (int i = 0; i < SS; i++) begin
      step();
      chk({tag, "_valid_hold"}, {31'd0, mgnt_valid}, 32'd1);
    end
    step();
    chk({tag, "_valid_fall"}, {31'd0, mgnt_valid}, 32'd0);
    chk({tag, "_data_stable"}, {12'd0, mgnt_data}, {12'd0, last_rec});
  endtask

  task automatic ack_release();
    mgnt_resp = 1'b0;
    model_release();
  endtask

  task automatic handshake(input string tag);
    accept_front(tag);
    repeat ($urandom_range(0, 5)) step();
    ack_raise(tag);
    ack_release();
    step();
  endtask

  initial begin
    logic [DW-1:0] rec;

    // Reset state
    rst_if = 1'b0;
    repeat (3) step();
    chk("rst_valid", {31'd0, mgnt_valid}, 32'd0);
    chk("rst_data", {12'd0, mgnt_data}, 32'd0);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    rst_if = 1'b1;
    step();

    // T1: single record, data leads valid by one cycle
    drive({8'h00, 12'd64});
    chk("t1_load_valid", {31'd0, mgnt_valid}, 32'd0);
    step();
    chk("t1_data_lead", {12'd0, mgnt_data}, 32'h00040);
    chk("t1_req_valid", {31'd0, mgnt_valid}, 32'd0);
    step();
    chk("t1_valid_cyc3", {31'd0, mgnt_valid}, 32'd1);
    accept_front("t1");
    repeat (6) step();
    chk("t1_wait_valid", {31'd0, mgnt_valid}, 32'd1);
    ack_raise("t1");
    ack_release();
    repeat (3) step();
    chk("t1_idle_valid", {31'd0, mgnt_valid}, 32'd0);
    chk("t1_idle_full", {31'd0, fifo_full}, 32'd0);
    chk("t1_data_kept", {12'd0, mgnt_data}, 32'h00040);

    // T2: park one record in WACK, then a 6-pulse burst overfills the queue
    rec = DW'($urandom);
    drive(rec);
    accept_front("t2_a");
    for (int i = 0; i < 6; i++) begin
      rec = {FW'($urandom), LW'(60 + i)};
      drive(rec);
    end
    chk("t2_full", {31'd0, fifo_full}, {31'd0, occ == FD});
    chk("t2_drop", {16'd0, drop_cnt}, exp_drop);
    ack_raise("t2_a");

    // T3: resp low reaches the FSM 2 cycles later, IDLE 1 more, LOAD the next; push into that LOAD
    ack_release();
    repeat (SS + 2) step();
    rec = DW'($urandom);
    drive(rec);
    chk("t3_drop", {16'd0, drop_cnt}, exp_drop);
    chk("t3_full", {31'd0, fifo_full}, {31'd0, occ == FD});
    while (exp_q.size() > 0) handshake("t2t3");
    step();
    chk("t3_empty_full", {31'd0, fifo_full}, 32'd0);

    // T5: asynchronous reset while valid is high and the queue is full
    drive(DW'($urandom));
    accept_front("t5_c");
    for (int i = 0; i < FD; i++) drive(DW'($urandom));
    chk("t5_pre_full", {31'd0, fifo_full}, {31'd0, occ == FD});
    chk("t5_pre_drop", {16'd0, drop_cnt}, exp_drop);
    #3;
    rst_if = 1'b0;
    #1;
    model_reset();
    chk("t5_async_valid", {31'd0, mgnt_valid}, 32'd0);
    chk("t5_async_drop", {16'd0, drop_cnt}, exp_drop);
    chk("t5_async_full", {31'd0, fifo_full}, 32'd0);
    chk("t5_async_data", {12'd0, mgnt_data}, 32'd0);
    step();
    step();
    rst_if = 1'b1;
    step();
    drive(DW'($urandom));
    handshake("t5_f");

    // T4: stale resp held across reset release
    mgnt_resp = 1'b1;
    rst_if = 1'b0;
    step();
    step();
    model_reset();
    rst_if = 1'b1;
    repeat (3) step();
    drive(DW'($urandom));
    repeat (8) step();
    chk("t4_stale_hold", {31'd0, mgnt_valid}, 32'd0);
    mgnt_resp = 1'b0;
    repeat (SS + 2) step();
    chk("t4_pre_rise", {31'd0, mgnt_valid}, 32'd0);
    step();
    chk("t4_valid_rise", {31'd0, mgnt_valid}, 32'd1);
    accept_front("t4");
    ack_raise("t4");
    ack_release();
    step();

    // T7: random traffic with random consumer delays
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        drive(DW'($urandom));
        repeat ($urandom_range(0, 2)) step();
      end
      while (exp_q.size() > 0) handshake("t7");
    end
    chk("t7_drop", {16'd0, drop_cnt}, exp_drop);

    // T6: drop counter saturation with no consumer response
    rst_if = 1'b0;
    step();
    model_reset();
    rst_if = 1'b1;
    step();
    rec = DW'($urandom);
    stat_valid = 1'b1;
    {stat_flags, stat_len} = rec;
    for (int i = 0; i < 70005; i++) begin
      model_push(rec);
      step();
      if (i == 999) chk("t6_drop_mid", {16'd0, drop_cnt}, exp_drop);
    end
    stat_valid = 1'b0;
    step();
    chk("t6_drop_sat", {16'd0, drop_cnt}, exp_drop);
    $display("rec t6: drop_cnt=%0h expected=%0h", drop_cnt, exp_drop);
    for (int i = 0; i < 10; i++) drive(rec);
    chk("t6_drop_hold", {16'd0, drop_cnt}, exp_drop);
    chk("t6_full", {31'd0, fifo_full}, {31'd0, occ == FD});
    chk("t6_valid_parked", {31'd0, mgnt_valid}, {31'd0, inflight});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
